id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- Pipeline register between ID and EX of the 5-stage core.
- Consumes the hazard unit's bubble request (control_select): on a load-use hazard, injects a NOP by zeroing control fields.
- Feeds EX, and feeds back ID_EX_memRead / ID_EX_rt to the hazard unit.
- Also supports branch flush and a downstream hold (EX/MEM stall).

Parameters:
- DATA_W, 32, width of datapath values (register operands, immediate, PC+4).
- REG_ADDR_W, 5, register-index width.
- ALUOP_W, 2, ALUOp field width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- control_select  in  1  bubble request from hazard unit; 1 = insert NOP.
- flush  in  1  branch/jump redirect; kill the instruction entering EX.
- hold  in  1  downstream stall; register keeps its contents.
- id_valid  in  1  ID holds a real instruction.
- id_regDst, id_aluSrc, id_memtoReg, id_regWrite, id_memRead, id_memWrite, id_branch  in  1 each  decoded controls.
- id_aluOp  in  ALUOP_W  decoded ALUOp.
- id_pc4  in  DATA_W  PC+4 of the ID instruction.
- id_rd1, id_rd2  in  DATA_W  register-file read data.
- id_imm  in  DATA_W  sign-extended immediate.
- id_rs, id_rt, id_rd  in  REG_ADDR_W  register indices.
- ex_valid  out  1  EX holds a real instruction.
- ID_EX_regDst … ID_EX_branch, ID_EX_aluOp  out  matching widths  registered controls.
- ID_EX_pc4, ID_EX_rd1, ID_EX_rd2, ID_EX_imm  out  DATA_W  registered data.
- ID_EX_rs, ID_EX_rt, ID_EX_rd  out  REG_ADDR_W  registered indices.
- ID_EX_memRead and ID_EX_rt also route to the hazard unit.

Behaviour:
- All state updates on rising clk only; there are no asynchronous paths.
- Reset (rst_n=0 at an edge): every output is 0, including ex_valid, all controls, all data and all indices. Reset overrides every other input, including mid-hold.
- Priority at each edge: reset > flush > hold > bubble > load.
- Flush: control outputs and ex_valid cleared to 0. Data and index fields are loaded from ID but are don't-care. Flush wins over an asserted hold.
- Hold (flush=0): every output keeps its previous value. control_select is ignored, so no bubble is counted.
- Bubble (control_select=1, no flush, no hold):
  - regWrite, memRead, memWrite, branch, regDst, aluSrc, memtoReg, aluOp and ex_valid all become 0.
  - Data and index fields load normally; harmless, and they ease waveform debug.
- Load (otherwise): all fields captured from the id_* inputs; ex_valid <= id_valid.
- When id_valid=0 on a load, controls are still captured as presented. The decoder guarantees zeros for invalid instructions, and the block does not mask them.
- Latency is exactly 1 cycle from ID inputs to ID_EX outputs.
- Controls are never partially cleared. A bubble or flush zeroes the whole control bundle in the same edge.
- Combinational path: none from input to output. The hazard-unit feedback is purely registered.

Optional Feature:
- Macro: ID_EX_BUBBLE_COUNT_EN.
- Defined:
  - Adds output bubble_count (32 bits).
  - Increments by 1 on every edge that performs a bubble (the bubble branch of the priority, not flush or hold).
  - Saturates at 32'hFFFF_FFFF.
  - Cleared to 0 by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - DATA_W, REG_ADDR_W and ALUOP_W defaults.
  - ALUOp encodings (ADD=2'b00, SUB=2'b01, RTYPE=2'b10).
  - A packed control-bundle typedef ctrl_t with regDst, aluSrc, memtoReg, regWrite, memRead, memWrite, branch and aluOp.
  - The constant CTRL_NOP = all-zero ctrl_t.
- One sub-module is natural: ctrl_bubble_mux.
  - Combinational; selects CTRL_NOP vs the decoded ctrl_t from control_select | flush.
  - The same mux is reused in the IF/ID and EX/MEM stages.

Test Plan:
- Reset: drive all id_* to nonzero (id_rd1=32'hDEADBEEF, id_regWrite=1), rst_n=0 for 2 edges → all outputs 0 and ex_valid=0. Release → the next edge loads 32'hDEADBEEF.
- Normal load: lw decode (memRead=1, regWrite=1, aluSrc=1, memtoReg=1, id_rt=5'd8, id_imm=32'h4) → after 1 edge ID_EX_memRead=1, ID_EX_rt=8, ex_valid=1.
- Load-use bubble: control_select=1 with add decode (regWrite=1, aluOp=2'b10) → after the edge all controls 0 and ex_valid=0. With ID_EX_BUBBLE_COUNT_EN, bubble_count goes 0→1.
- Flush vs hold: hold=1 and flush=1 in the same cycle → controls cleared. Then hold=1 alone for 3 cycles → outputs frozen at the prior values across all 3 edges.
- Hold masks bubble: hold=1, control_select=1 → outputs unchanged and bubble_count unchanged.
- Reset mid-hold, plus counter saturation:
  - Hold with ex_valid=1, then rst_n=0 → outputs 0 on that edge.
  - Force bubble_count to 32'hFFFFFFFE, apply 3 bubbles → 32'hFFFFFFFF and stays there.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths, ALUOp encodings and the
// packed control bundle carried between stages.
package pipe_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALUOP_W    = 2;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;

    typedef struct packed {
        logic               regDst;
        logic               aluSrc;
        logic               memtoReg;
        logic               regWrite;
        logic               memRead;
        logic               memWrite;
        logic               branch;
        logic [ALUOP_W-1:0] aluOp;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_bubble_mux.sv
// Replaces a decoded control bundle with CTRL_NOP when the stage must kill
// the instruction (bubble or flush). Purely combinational.
module ctrl_bubble_mux
    import pipe_pkg::*;
(
    input  logic  kill,
    input  ctrl_t ctrl_in,
    output ctrl_t ctrl_out
);

    // The whole bundle is swapped at once so no control is ever half-cleared.
    assign ctrl_out = kill ? CTRL_NOP : ctrl_in;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with bubble injection, branch flush and hold.
// Optional macro ID_EX_BUBBLE_COUNT_EN adds a saturating bubble_count output.
module id_ex_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W     = pipe_pkg::DATA_W,
    parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W,
    parameter int ALUOP_W    = pipe_pkg::ALUOP_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  control_select,
    input  logic                  flush,
    input  logic                  hold,
    input  logic                  id_valid,
    input  logic                  id_regDst,
    input  logic                  id_aluSrc,
    input  logic                  id_memtoReg,
    input  logic                  id_regWrite,
    input  logic                  id_memRead,
    input  logic                  id_memWrite,
    input  logic                  id_branch,
    input  logic [ALUOP_W-1:0]    id_aluOp,
    input  logic [DATA_W-1:0]     id_pc4,
    input  logic [DATA_W-1:0]     id_rd1,
    input  logic [DATA_W-1:0]     id_rd2,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    output logic                  ex_valid,
    output logic                  ID_EX_regDst,
    output logic                  ID_EX_aluSrc,
    output logic                  ID_EX_memtoReg,
    output logic                  ID_EX_regWrite,
    output logic                  ID_EX_memRead,
    output logic                  ID_EX_memWrite,
    output logic                  ID_EX_branch,
    output logic [ALUOP_W-1:0]    ID_EX_aluOp,
    output logic [DATA_W-1:0]     ID_EX_pc4,
    output logic [DATA_W-1:0]     ID_EX_rd1,
    output logic [DATA_W-1:0]     ID_EX_rd2,
    output logic [DATA_W-1:0]     ID_EX_imm,
    output logic [REG_ADDR_W-1:0] ID_EX_rs,
    output logic [REG_ADDR_W-1:0] ID_EX_rt,
    output logic [REG_ADDR_W-1:0] ID_EX_rd
`ifdef ID_EX_BUBBLE_COUNT_EN
    ,
    output logic [31:0]           bubble_count
`endif
);

    ctrl_t id_ctrl;
    ctrl_t ctrl_next;
    ctrl_t ctrl_q;
    logic  kill;
    logic  valid_next;
    logic  load_en;
    logic  valid_q;

    logic [DATA_W-1:0]     pc4_q, rd1_q, rd2_q, imm_q;
    logic [REG_ADDR_W-1:0] rs_q, rt_q, rd_q;

    assign id_ctrl = '{
        regDst:   id_regDst,
        aluSrc:   id_aluSrc,
        memtoReg: id_memtoReg,
        regWrite: id_regWrite,
        memRead:  id_memRead,
        memWrite: id_memWrite,
        branch:   id_branch,
        aluOp:    id_aluOp
    };

    assign kill       = control_select | flush;
    assign valid_next = id_valid & ~kill;
    // Flush must still take effect while the downstream stage is holding.
    assign load_en    = flush | ~hold;

    ctrl_bubble_mux u_ctrl_mux (
        .kill     (kill),
        .ctrl_in  (id_ctrl),
        .ctrl_out (ctrl_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q  <= CTRL_NOP;
            valid_q <= 1'b0;
            pc4_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
        end else if (load_en) begin
            ctrl_q  <= ctrl_next;
            valid_q <= valid_next;
            pc4_q   <= id_pc4;
            rd1_q   <= id_rd1;
            rd2_q   <= id_rd2;
            imm_q   <= id_imm;
            rs_q    <= id_rs;
            rt_q    <= id_rt;
            rd_q    <= id_rd;
        end
    end

`ifdef ID_EX_BUBBLE_COUNT_EN
    logic [31:0] bubble_count_q;
    logic        bubble_fire;

    // Only the bubble branch counts; flush and hold both take precedence.
    assign bubble_fire = control_select & ~flush & ~hold;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_count_q <= '0;
        end else if (bubble_fire && (bubble_count_q != 32'hFFFF_FFFF)) begin
            bubble_count_q <= bubble_count_q + 32'd1;
        end
    end

    assign bubble_count = bubble_count_q;
`endif

    assign ex_valid       = valid_q;
    assign ID_EX_regDst   = ctrl_q.regDst;
    assign ID_EX_aluSrc   = ctrl_q.aluSrc;
    assign ID_EX_memtoReg = ctrl_q.memtoReg;
    assign ID_EX_regWrite = ctrl_q.regWrite;
    assign ID_EX_memRead  = ctrl_q.memRead;
    assign ID_EX_memWrite = ctrl_q.memWrite;
    assign ID_EX_branch   = ctrl_q.branch;
    assign ID_EX_aluOp    = ctrl_q.aluOp;
    assign ID_EX_pc4      = pc4_q;
    assign ID_EX_rd1      = rd1_q;
    assign ID_EX_rd2      = rd2_q;
    assign ID_EX_imm      = imm_q;
    assign ID_EX_rs       = rs_q;
    assign ID_EX_rt       = rt_q;
    assign ID_EX_rd       = rd_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg against a per-edge priority model
// (reset > flush > hold > bubble > load); covers bubble_count when enabled.
module tb_id_ex_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        control_select, flush, hold, id_valid;
    logic        id_regDst, id_aluSrc, id_memtoReg, id_regWrite;
    logic        id_memRead, id_memWrite, id_branch;
    logic [1:0]  id_aluOp;
    logic [31:0] id_pc4, id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;

    logic        ex_valid;
    logic        ID_EX_regDst, ID_EX_aluSrc, ID_EX_memtoReg, ID_EX_regWrite;
    logic        ID_EX_memRead, ID_EX_memWrite, ID_EX_branch;
    logic [1:0]  ID_EX_aluOp;
    logic [31:0] ID_EX_pc4, ID_EX_rd1, ID_EX_rd2, ID_EX_imm;
    logic [4:0]  ID_EX_rs, ID_EX_rt, ID_EX_rd;
`ifdef ID_EX_BUBBLE_COUNT_EN
    logic [31:0] bubble_count;
    logic [31:0] exp_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Model state: 10-bit {ex_valid, controls} and 143-bit data/index bundle.
    logic [9:0]   exp_ctrl;
    logic [142:0] exp_data;
    bit           exp_known;

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk(clk), .rst_n(rst_n), .control_select(control_select),
        .flush(flush), .hold(hold), .id_valid(id_valid),
        .id_regDst(id_regDst), .id_aluSrc(id_aluSrc), .id_memtoReg(id_memtoReg),
        .id_regWrite(id_regWrite), .id_memRead(id_memRead),
        .id_memWrite(id_memWrite), .id_branch(id_branch), .id_aluOp(id_aluOp),
        .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_valid(ex_valid), .ID_EX_regDst(ID_EX_regDst),
        .ID_EX_aluSrc(ID_EX_aluSrc), .ID_EX_memtoReg(ID_EX_memtoReg),
        .ID_EX_regWrite(ID_EX_regWrite), .ID_EX_memRead(ID_EX_memRead),
        .ID_EX_memWrite(ID_EX_memWrite), .ID_EX_branch(ID_EX_branch),
        .ID_EX_aluOp(ID_EX_aluOp), .ID_EX_pc4(ID_EX_pc4), .ID_EX_rd1(ID_EX_rd1),
        .ID_EX_rd2(ID_EX_rd2), .ID_EX_imm(ID_EX_imm), .ID_EX_rs(ID_EX_rs),
        .ID_EX_rt(ID_EX_rt), .ID_EX_rd(ID_EX_rd)
`ifdef ID_EX_BUBBLE_COUNT_EN
        , .bubble_count(bubble_count)
`endif
    );

    function automatic logic [9:0] obs_ctrl();
        return {ex_valid, ID_EX_regDst, ID_EX_aluSrc, ID_EX_memtoReg, ID_EX_regWrite,
                ID_EX_memRead, ID_EX_memWrite, ID_EX_branch, ID_EX_aluOp};
    endfunction

    function automatic logic [142:0] obs_data();
        return {ID_EX_pc4, ID_EX_rd1, ID_EX_rd2, ID_EX_imm, ID_EX_rs, ID_EX_rt, ID_EX_rd};
    endfunction

    // Apply the priority rules to the inputs present just before the edge.
    task automatic model_edge();
        logic [9:0] in_ctrl;
        in_ctrl = {id_valid, id_regDst, id_aluSrc, id_memtoReg, id_regWrite,
                   id_memRead, id_memWrite, id_branch, id_aluOp};
        if (!rst_n) begin
            exp_ctrl  = '0;
            exp_data  = '0;
            exp_known = 1'b1;
`ifdef ID_EX_BUBBLE_COUNT_EN
            exp_cnt = 0;
`endif
        end else if (flush) begin
            exp_ctrl  = '0;
            exp_known = 1'b0;
        end else if (hold) begin
            // everything retained
        end else begin
            exp_data  = {id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd};
            exp_known = 1'b1;
            if (control_select) begin
                exp_ctrl = '0;
`ifdef ID_EX_BUBBLE_COUNT_EN
                if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
`endif
            end else begin
                exp_ctrl = in_ctrl;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_id();
        {id_valid, id_regDst, id_aluSrc, id_memtoReg, id_regWrite} = 5'($urandom);
        {id_memRead, id_memWrite, id_branch} = 3'($urandom);
        id_aluOp = 2'($urandom_range(0, 2));
        id_pc4 = $urandom; id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
        id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
    endtask

    task automatic test_reset();
        randomize_id();
        id_rd1 = 32'hDEADBEEF; id_regWrite = 1'b1; id_valid = 1'b1;
        control_select = 0; flush = 0; hold = 0; rst_n = 0;
        tick(); tick();
        checks++;
        if (obs_ctrl() !== 10'd0) begin
            failures++;
            $display("FAIL reset_ctrl got=%h want=0", obs_ctrl());
        end
        checks++;
        if (obs_data() !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h want=0", obs_data());
        end
`ifdef ID_EX_BUBBLE_COUNT_EN
        checks++;
        if (bubble_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_count got=%h want=0", bubble_count);
        end
`endif
        rst_n = 1;
        tick();
        checks++;
        if (ID_EX_rd1 !== 32'hDEADBEEF || ID_EX_regWrite !== 1'b1 || ex_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_release got rd1=%h rw=%b v=%b want rd1=deadbeef rw=1 v=1",
                     ID_EX_rd1, ID_EX_regWrite, ex_valid);
        end
    endtask

    task automatic test_load();
        randomize_id();
        id_valid = 1; id_memRead = 1; id_regWrite = 1; id_aluSrc = 1; id_memtoReg = 1;
        id_memWrite = 0; id_branch = 0; id_regDst = 0; id_aluOp = 2'b00;
        id_rt = 5'd8; id_imm = 32'h4;
        tick();
        checks++;
        if (ID_EX_memRead !== 1'b1 || ID_EX_rt !== 5'd8 || ex_valid !== 1'b1 || ID_EX_imm !== 32'h4) begin
            failures++;
            $display("FAIL load_lw got mr=%b rt=%0d v=%b imm=%h want mr=1 rt=8 v=1 imm=4",
                     ID_EX_memRead, ID_EX_rt, ex_valid, ID_EX_imm);
        end
        checks++;
        if (obs_ctrl() !== exp_ctrl || obs_data() !== exp_data) begin
            failures++;
            $display("FAIL load_full got=%h/%h want=%h/%h", obs_ctrl(), obs_data(), exp_ctrl, exp_data);
        end
    endtask

    task automatic test_bubble();
        randomize_id();
        id_valid = 1; id_regWrite = 1; id_aluOp = 2'b10; id_regDst = 1;
        control_select = 1;
        tick();
        control_select = 0;
        checks++;
        if (obs_ctrl() !== 10'd0) begin
            failures++;
            $display("FAIL bubble_ctrl got=%h want=0", obs_ctrl());
        end
        checks++;
        if (obs_data() !== exp_data) begin
            failures++;
            $display("FAIL bubble_data got=%h want=%h", obs_data(), exp_data);
        end
`ifdef ID_EX_BUBBLE_COUNT_EN
        checks++;
        if (bubble_count !== 32'd1) begin
            failures++;
            $display("FAIL bubble_count got=%0d want=1", bubble_count);
        end
`endif
    endtask

    task automatic test_flush_hold();
        randomize_id();
        id_valid = 1; id_regWrite = 1; id_branch = 1;
        tick();
        randomize_id();
        id_valid = 1; id_regWrite = 1;
        hold = 1; flush = 1;
        tick();
        flush = 0;
        checks++;
        if (obs_ctrl() !== 10'd0) begin
            failures++;
            $display("FAIL flush_over_hold got=%h want=0", obs_ctrl());
        end
        // Reload a live instruction, then freeze it for three edges.
        hold = 0;
        randomize_id();
        id_valid = 1; id_memWrite = 1;
        tick();
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            randomize_id();
            control_select = 1'($urandom);
            tick();
            checks++;
            if (obs_ctrl() !== exp_ctrl || obs_data() !== exp_data || ID_EX_memWrite !== 1'b1) begin
                failures++;
                $display("FAIL hold_freeze[%0d] got=%h/%h want=%h/%h", i,
                         obs_ctrl(), obs_data(), exp_ctrl, exp_data);
            end
        end
        control_select = 0; hold = 0;
    endtask

    task automatic test_hold_masks_bubble();
`ifdef ID_EX_BUBBLE_COUNT_EN
        logic [31:0] cnt_before;
        cnt_before = exp_cnt;
`endif
        randomize_id();
        id_valid = 1; id_regWrite = 1;
        tick();
        hold = 1; control_select = 1;
        randomize_id();
        tick();
        checks++;
        if (obs_ctrl() !== exp_ctrl || ex_valid !== 1'b1 || ID_EX_regWrite !== 1'b1) begin
            failures++;
            $display("FAIL hold_masks_bubble got=%h want=%h", obs_ctrl(), exp_ctrl);
        end
`ifdef ID_EX_BUBBLE_COUNT_EN
        checks++;
        if (bubble_count !== cnt_before) begin
            failures++;
            $display("FAIL hold_masks_count got=%0d want=%0d", bubble_count, cnt_before);
        end
`endif
        hold = 0; control_select = 0;
    endtask

    task automatic test_reset_mid_hold();
        randomize_id();
        id_valid = 1; id_memRead = 1;
        tick();
        hold = 1;
        tick();
        rst_n = 0;
        tick();
        checks++;
        if (obs_ctrl() !== 10'd0 || obs_data() !== '0) begin
            failures++;
            $display("FAIL reset_mid_hold got=%h/%h want=0/0", obs_ctrl(), obs_data());
        end
        rst_n = 1; hold = 0;
    endtask

`ifdef ID_EX_BUBBLE_COUNT_EN
    task automatic test_saturation();
        hold = 1;
        force dut.bubble_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.bubble_count_q;
        exp_cnt = 32'hFFFF_FFFE;
        hold = 0; control_select = 1;
        for (int i = 0; i < 3; i++) begin
            randomize_id();
            tick();
            checks++;
            if (bubble_count !== 32'hFFFF_FFFF) begin
                failures++;
                $display("FAIL saturate[%0d] got=%h want=ffffffff", i, bubble_count);
            end
        end
        control_select = 0;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            randomize_id();
            rst_n          = ($urandom_range(0, 39) != 0);
            flush          = ($urandom_range(0, 7) == 0);
            hold           = ($urandom_range(0, 4) == 0);
            control_select = ($urandom_range(0, 3) == 0);
            tick();
            checks++;
            if (obs_ctrl() !== exp_ctrl) begin
                failures++;
                $display("FAIL rand_ctrl[%0d] got=%h want=%h", i, obs_ctrl(), exp_ctrl);
            end
            if (exp_known) begin
                checks++;
                if (obs_data() !== exp_data) begin
                    failures++;
                    $display("FAIL rand_data[%0d] got=%h want=%h", i, obs_data(), exp_data);
                end
            end
`ifdef ID_EX_BUBBLE_COUNT_EN
            checks++;
            if (bubble_count !== exp_cnt) begin
                failures++;
                $display("FAIL rand_count[%0d] got=%0d want=%0d", i, bubble_count, exp_cnt);
            end
`endif
        end
        rst_n = 1; flush = 0; hold = 0; control_select = 0;
    endtask

    initial begin
        exp_ctrl = '0; exp_data = '0; exp_known = 1'b0;
`ifdef ID_EX_BUBBLE_COUNT_EN
        exp_cnt = 0;
`endif
        test_reset();
        test_load();
        test_bubble();
        test_flush_hold();
        test_hold_masks_bubble();
        test_reset_mid_hold();
`ifdef ID_EX_BUBBLE_COUNT_EN
        test_saturation();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
